// File: rtl/div_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// div_sequencer_pkg
//   Shared definitions for the RV32IM divide sequencer:
//   - default operand width
//   - funct3 codes of the four divide ops
//   - 2-bit FSM state encoding
//   - small decode helpers on funct3
// ----------------------------------------------------------------------------
package div_sequencer_pkg;

    localparam int DEF_XLEN = 32;

    // funct3 codes; bit 2 marks a divide op, bit 1 selects the remainder,
    // bit 0 selects unsigned operation.
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIN  = 2'b10
    } state_t;

    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] f3);
        return f3[1];
    endfunction

    function automatic logic is_signed_op(input logic [2:0] f3);
        return ~f3[0];
    endfunction

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   The MSB of the quotient/dividend register is shifted into the partial
//   remainder, the divisor is trial-subtracted, and the resulting quotient bit
//   enters at the LSB of the quotient register.
// Ports
//   rem_in   [XLEN:0]    partial remainder before the step
//   quo_in   [XLEN-1:0]  dividend bits not yet consumed / quotient so far
//   divisor  [XLEN-1:0]  unsigned divisor
//   rem_out  [XLEN:0]    partial remainder after the step
//   quo_out  [XLEN-1:0]  shifted quotient with the new bit in the LSB
// ----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;
    logic            borrow;

    // One extra bit above the remainder so the trial subtraction's sign is
    // unambiguous for every remainder/divisor combination.
    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign trial   = shifted - {2'b00, divisor};
    assign borrow  = trial[XLEN+1];

    always_comb begin
        rem_out = borrow ? shifted[XLEN:0] : trial[XLEN:0];
        quo_out = {quo_in[XLEN-2:0], ~borrow};
    end

endmodule

// File: rtl/div_sequencer.sv
// ----------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle DIV/DIVU/REM/REMU unit beside the EX-stage ALU.
//   An accepted op runs XLEN restoring iterations (CALC), then presents the
//   sign-corrected result for one cycle (FIN). Divide-by-zero and signed
//   overflow bypass CALC and go straight to FIN with the RISC-V defined result.
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-low reset
//   start      ID/EX holds a valid op for this unit
//   funct3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   operand_a  dividend (rs1)
//   operand_b  divisor (rs2)
//   rd_in      destination register tag
//   flush      kill of the in-flight op
//   stall      combinational freeze of IF/ID/EX and PC
//   busy       registered, state != IDLE
//   done       registered one-cycle result-valid pulse
//   result     final quotient or remainder
//   rd_out     tag of the op that produced result
// ----------------------------------------------------------------------------
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN:0]    rem_reg;
    logic [XLEN-1:0]  quo_reg;
    logic [XLEN-1:0]  divisor_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             is_rem_reg;
    logic [4:0]       rd_tag_reg;
    logic             done_reg;
    logic             busy_reg;
    logic [XLEN-1:0]  result_reg;
    logic [4:0]       rd_out_reg;

    // ------------------------------------------------------------------
    // Operand decode at the accept edge
    // ------------------------------------------------------------------
    logic            op_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_by_zero, overflow, special;
    logic [XLEN-1:0] special_result;

    assign op_signed   = is_signed_op(funct3);
    assign a_neg       = op_signed & operand_a[XLEN-1];
    assign b_neg       = op_signed & operand_b[XLEN-1];
    assign a_abs       = a_neg ? -operand_a : operand_a;
    assign b_abs       = b_neg ? -operand_b : operand_b;
    assign div_by_zero = (operand_b == '0);
    assign overflow    = op_signed & (operand_a == MIN_NEG) & (operand_b == '1);
    assign special     = div_by_zero | overflow;

    always_comb begin
        special_result = '0;
        if (div_by_zero) begin
            special_result = is_rem_op(funct3) ? operand_a : '1;
        end else begin
            // Signed overflow: quotient is the dividend itself, remainder 0.
            special_result = is_rem_op(funct3) ? '0 : operand_a;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath and final sign fix-up
    // ------------------------------------------------------------------
    logic [XLEN:0]   rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] final_q, final_r;
    logic            last_step;

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (divisor_reg),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    assign last_step = (cnt_reg == LAST_CNT);
    // Results are taken straight from the last step's outputs so they are
    // loaded on the same edge the FSM enters FIN.
    assign final_q   = neg_q_reg ? -quo_step : quo_step;
    assign final_r   = neg_r_reg ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];

    // ------------------------------------------------------------------
    // FSM next-state and control
    // ------------------------------------------------------------------
    logic accept;
    logic calc_step;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        calc_step  = 1'b0;
        stall      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall  = start & is_div_op(funct3);
                accept = start & is_div_op(funct3) & ~flush;
                if (accept) begin
                    state_next = special ? ST_FIN : ST_CALC;
                end
            end
            ST_CALC: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    calc_step = 1'b1;
                    if (last_step) begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                // The held op leaves ID/EX on this edge; start is ignored.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            is_rem_reg  <= 1'b0;
            rd_tag_reg  <= '0;
            done_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            result_reg  <= '0;
            rd_out_reg  <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_FIN);

            if (accept) begin
                cnt_reg     <= '0;
                rem_reg     <= '0;
                quo_reg     <= a_abs;
                divisor_reg <= b_abs;
                neg_q_reg   <= a_neg ^ b_neg;
                neg_r_reg   <= a_neg;
                is_rem_reg  <= is_rem_op(funct3);
                rd_tag_reg  <= rd_in;
                if (special) begin
                    result_reg <= special_result;
                    rd_out_reg <= rd_in;
                end
            end

            if (calc_step) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= cnt_reg + CNT_W'(1);
                if (last_step) begin
                    result_reg <= is_rem_reg ? final_r : final_q;
                    rd_out_reg <= rd_tag_reg;
                end
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;
    assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_div_sequencer.sv
// ----------------------------------------------------------------------------
// tb_div_sequencer
//   Self-checking bench: directed vector table, flush/reset/back-to-back
//   sequences, and randomized ops checked against an arithmetic model.
// ----------------------------------------------------------------------------
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .rd_in     (rd_in),
        .flush     (flush),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain RISC-V division semantics on 64-bit integers.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        case (f3)
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb;
                return q[31:0];
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                q = sa % sb;
                return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Presents an op and waits for done. lat counts edges from the first
    // edge after presentation up to the edge after which done is seen.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit hold_start,
                          output logic [31:0] res, output logic [4:0] rdo,
                          output int lat, output int stalls, output int unsigned done_cyc);
        start     = 1'b1;
        funct3    = f3;
        operand_a = a;
        operand_b = b;
        rd_in     = rd;
        lat       = -1;
        stalls    = 0;
        res       = '0;
        rdo       = '0;
        done_cyc  = 0;
        for (int e = 0; e < 60; e++) begin
            @(negedge clk);
            if (stall) stalls++;
            @(posedge clk);
            #1;
            if (done) begin
                lat      = e + 1;
                res      = result;
                rdo      = rd_out;
                done_cyc = cyc;
                break;
            end
            // Operands are only sampled at accept; scramble them afterwards.
            if (busy) begin
                operand_a = $urandom;
                operand_b = $urandom;
                rd_in     = 5'($urandom);
            end
        end
        if (lat < 0) chk("done_timeout", 32'hFFFF_FFFF, 32'd0);
        if (!hold_start) start = 1'b0;
    endtask

    // Runs one op to completion and checks result, tag, latency, stall count
    // and that done is a single-cycle pulse with result held afterwards.
    task automatic check_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, stalls;
        int unsigned dc;
        run_op(f3, a, b, rd, 1'b0, res, rdo, lat, stalls, dc);
        $display("op f3=%b a=%h b=%h rd=%0d result=%h rd_out=%0d lat=%0d stall_cycles=%0d",
                 f3, a, b, rd, res, rdo, lat, stalls);
        chk("result", res, exp);
        chk("rd_out", {27'd0, rdo}, {27'd0, rd});
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("stall_cycles", 32'(stalls), 32'(exp_lat));
        @(negedge clk);
        chk("stall_in_fin", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse_width", {31'd0, done}, 32'd0);
        chk("result_held", result, exp);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] res1, res2;
        logic [4:0]  rdo1, rdo2;
        int          lat1, lat2, st1, st2;
        int unsigned dc1, dc2;
        logic [31:0] prev_result;
        bit          saw_done;

        vecs[0] = '{F3_DIV,  32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, 33};
        vecs[1] = '{F3_REM,  32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 33};
        vecs[2] = '{F3_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd5,  32'hFFFF_FFFF, 33};
        vecs[3] = '{F3_REMU, 32'd100,       32'd7,         5'd6,  32'd2,         33};
        vecs[4] = '{F3_DIVU, 32'd5,         32'd0,         5'd7,  32'hFFFF_FFFF, 1};
        vecs[5] = '{F3_REMU, 32'd5,         32'd0,         5'd8,  32'd5,         1};
        vecs[6] = '{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1};
        vecs[7] = '{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1};
        vecs[8] = '{F3_DIV,  32'd7,         32'hFFFF_FFFE, 5'd30, 32'hFFFF_FFFD, 33};
        vecs[9] = '{F3_REM,  32'd7,         32'hFFFF_FFFE, 5'd31, 32'd1,         33};

        rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'b000;
        operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",   {31'd0, busy},   32'd0);
        chk("reset_done",   {31'd0, done},   32'd0);
        chk("reset_stall",  {31'd0, stall},  32'd0);
        chk("reset_result", result,          32'd0);
        chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
        rst = 1'b1;

        // Non-divide funct3 is ignored; flush blocks acceptance in IDLE.
        start = 1'b1; funct3 = 3'b000; operand_a = 32'd9; operand_b = 32'd3;
        @(negedge clk);
        chk("nondiv_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("nondiv_busy", {31'd0, busy}, 32'd0);
        funct3 = F3_DIV; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_blocks_accept", {31'd0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            check_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);
        end

        // Flush mid-CALC: nothing completes, previous result and tag are kept.
        check_op(F3_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, 33);
        prev_result = result;
        start = 1'b1; funct3 = F3_DIV; operand_a = 32'd1000; operand_b = 32'd3; rd_in = 5'd12;
        saw_done = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        if (done) saw_done = 1'b1;
        flush = 1'b0;
        $display("flush at cnt=10 busy=%0d done=%0d result=%h rd_out=%0d", busy, done, result, rd_out);
        chk("flush_busy",    {31'd0, busy},     32'd0);
        chk("flush_no_done", {31'd0, saw_done}, 32'd0);
        chk("flush_result",  result,            prev_result);
        chk("flush_rd_out",  {27'd0, rd_out},   32'd9);
        check_op(F3_DIVU, 32'd1000, 32'd3, 5'd13, 32'd333, 33);

        // Reset mid-CALC.
        start = 1'b1; funct3 = F3_DIVU; operand_a = 32'd77; operand_b = 32'd5; rd_in = 5'd20;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        $display("reset mid-calc busy=%0d done=%0d stall=%0d result=%h rd_out=%0d",
                 busy, done, stall, result, rd_out);
        chk("midreset_busy",   {31'd0, busy},   32'd0);
        chk("midreset_done",   {31'd0, done},   32'd0);
        chk("midreset_stall",  {31'd0, stall},  32'd0);
        chk("midreset_result", result,          32'd0);
        chk("midreset_rd_out", {27'd0, rd_out}, 32'd0);
        rst = 1'b1;

        // Back-to-back ops: second is presented during FIN of the first.
        run_op(F3_DIVU, 32'd1000, 32'd10, 5'd3, 1'b1, res1, rdo1, lat1, st1, dc1);
        run_op(F3_DIVU, 32'd81,   32'd9,  5'd4, 1'b0, res2, rdo2, lat2, st2, dc2);
        $display("b2b op1 result=%h rd=%0d lat=%0d  op2 result=%h rd=%0d lat=%0d gap=%0d",
                 res1, rdo1, lat1, res2, rdo2, lat2, dc2 - dc1);
        chk("b2b_res1", res1, 32'd100);
        chk("b2b_rd1",  {27'd0, rdo1}, 32'd3);
        chk("b2b_lat1", 32'(lat1), 32'd33);
        chk("b2b_res2", res2, 32'd9);
        chk("b2b_rd2",  {27'd0, rdo2}, 32'd4);
        chk("b2b_gap",  dc2 - dc1, 32'd34);
        chk("b2b_stall2", 32'(st2), 32'd33);
        @(posedge clk); #1;

        // Randomized ops against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int unsigned sel;
            f3  = 3'(4 + $urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom);
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = '0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: begin b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3)); end
                default: ;
            endcase
            check_op(f3, a, b, rd, ref_result(f3, a, b), ref_latency(f3, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
